// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302-compatible serial target: register map,
// command-byte layout, FSM states, reset values and the BCD step helper.
package ds1302_pkg;

  localparam logic [2:0] REG_SEC   = 3'd0;
  localparam logic [2:0] REG_MIN   = 3'd1;
  localparam logic [2:0] REG_HOUR  = 3'd2;
  localparam logic [2:0] REG_DATE  = 3'd3;
  localparam logic [2:0] REG_MONTH = 3'd4;
  localparam logic [2:0] REG_WEEK  = 3'd5;
  localparam logic [2:0] REG_YEAR  = 3'd6;
  localparam logic [2:0] REG_WP    = 3'd7;

  localparam int CMD_RD_BIT   = 0;
  localparam int CMD_ADDR_LSB = 1;
  localparam int CMD_ADDR_MSB = 5;
  localparam int CMD_RAM_BIT  = 6;
  localparam int CMD_ONE_BIT  = 7;

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, WAIT} state_e;

  localparam logic [7:0] RST_SEC   = 8'h00;
  localparam logic [7:0] RST_MIN   = 8'h00;
  localparam logic [7:0] RST_HOUR  = 8'h00;
  localparam logic [7:0] RST_DATE  = 8'h01;
  localparam logic [7:0] RST_MONTH = 8'h01;
  localparam logic [7:0] RST_WEEK  = 8'h01;
  localparam logic [7:0] RST_YEAR  = 8'h00;

  // Returns {carry, next} for a two-digit BCD counter that wraps after max_v.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [8:0] r;
    if (v == max_v)
      r = {1'b1, 8'h00};
    else if (v[3:0] == 4'd9)
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/ds1302_edge_sync.sv
// Brings the asynchronous three-wire inputs into the clk domain and derives
// single-clk rise/fall strobes for chip enable and serial clock.
module ds1302_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic dce_i,
  input  logic dclk_i,
  input  logic io_i,
  output logic dce_rise_o,
  output logic dce_fall_o,
  output logic dclk_rise_o,
  output logic dclk_fall_o,
  output logic io_o
);

  logic [SYNC_STAGES-1:0] dce_sync_q;
  logic [SYNC_STAGES-1:0] dclk_sync_q;
  logic [SYNC_STAGES-1:0] io_sync_q;
  logic                   dce_prev_q;
  logic                   dclk_prev_q;
  logic                   dce_s;
  logic                   dclk_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dce_sync_q  <= '0;
      dclk_sync_q <= '0;
      io_sync_q   <= '0;
      dce_prev_q  <= 1'b0;
      dclk_prev_q <= 1'b0;
    end else begin
      dce_sync_q[0]  <= dce_i;
      dclk_sync_q[0] <= dclk_i;
      io_sync_q[0]   <= io_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        dce_sync_q[i]  <= dce_sync_q[i-1];
        dclk_sync_q[i] <= dclk_sync_q[i-1];
        io_sync_q[i]   <= io_sync_q[i-1];
      end
      dce_prev_q  <= dce_s;
      dclk_prev_q <= dclk_s;
    end
  end

  assign dce_s       = dce_sync_q[SYNC_STAGES-1];
  assign dclk_s      = dclk_sync_q[SYNC_STAGES-1];
  assign io_o        = io_sync_q[SYNC_STAGES-1];
  assign dce_rise_o  = dce_s & ~dce_prev_q;
  assign dce_fall_o  = ~dce_s & dce_prev_q;
  assign dclk_rise_o = dclk_s & ~dclk_prev_q;
  assign dclk_fall_o = ~dclk_s & dclk_prev_q;

endmodule

// File: rtl/ds1302_slave.sv
// DS1302-compatible responder: decodes command frames, serves single-byte
// clock register reads/writes with write protect, and runs sec/min/hour.
module ds1302_slave
  import ds1302_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_WP      = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dce,
  input  logic       dclk,
  input  logic       io_in,
  output logic       io_out,
  output logic       io_oe,
  input  logic       tick_1hz,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] date,
  output logic [7:0] month,
  output logic [7:0] week,
  output logic [7:0] year,
  output logic       wp,
  output logic       frame_done,
  output state_e     state_o
);

  // Handshake: none -- the master owns dce/dclk; every action here is a
  // reaction to a synchronized dce or dclk edge, and frame_done is a 1-clk pulse.

  logic dce_rise, dce_fall, dclk_rise, dclk_fall, io_s;

  ds1302_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .reset_n     (reset_n),
    .dce_i       (dce),
    .dclk_i      (dclk),
    .io_i        (io_in),
    .dce_rise_o  (dce_rise),
    .dce_fall_o  (dce_fall),
    .dclk_rise_o (dclk_rise),
    .dclk_fall_o (dclk_fall),
    .io_o        (io_s)
  );

  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [2:0] addr_q;
  logic       commit_q;
  logic [7:0] regs_q [0:6];
  logic       wp_q;
  logic       io_out_q;
  logic       io_oe_q;
  logic       frame_done_q;

  logic [7:0] shift_d;
  logic       cmd_valid;
  logic [7:0] read_val;
  logic       commit_now;
  logic       tick_now;
  logic [8:0] sec_inc, min_inc, hour_inc;

  assign shift_d   = {io_s, shift_q[7:1]};
  assign cmd_valid = shift_d[CMD_ONE_BIT] & ~shift_d[CMD_RAM_BIT] &
                     (shift_d[CMD_ADDR_MSB:CMD_ADDR_LSB+3] == 2'b00);

  always_comb begin
    read_val = 8'h00;
    case (shift_d[CMD_ADDR_LSB+2:CMD_ADDR_LSB])
      REG_SEC:   read_val = regs_q[0];
      REG_MIN:   read_val = regs_q[1];
      REG_HOUR:  read_val = regs_q[2];
      REG_DATE:  read_val = regs_q[3];
      REG_MONTH: read_val = regs_q[4];
      REG_WEEK:  read_val = regs_q[5];
      REG_YEAR:  read_val = regs_q[6];
      default:   read_val = {wp_q, 7'b0};
    endcase
  end

  // A register write landing in the same clk as a tick wins; the tick is lost.
  assign commit_now = (state_q == WDATA) && commit_q && !dce_fall;
  assign tick_now   = tick_1hz && !regs_q[0][7] && !commit_now;
  assign sec_inc    = bcd_inc(regs_q[0], 8'h59);
  assign min_inc    = bcd_inc(regs_q[1], 8'h59);
  assign hour_inc   = bcd_inc(regs_q[2], 8'h23);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      addr_q       <= 3'd0;
      commit_q     <= 1'b0;
      regs_q[0]    <= RST_SEC;
      regs_q[1]    <= RST_MIN;
      regs_q[2]    <= RST_HOUR;
      regs_q[3]    <= RST_DATE;
      regs_q[4]    <= RST_MONTH;
      regs_q[5]    <= RST_WEEK;
      regs_q[6]    <= RST_YEAR;
      wp_q         <= RST_WP;
      io_out_q     <= 1'b0;
      io_oe_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (tick_now) begin
        regs_q[0] <= sec_inc[7:0];
        if (sec_inc[8]) begin
          regs_q[1] <= min_inc[7:0];
          if (min_inc[8])
            regs_q[2] <= hour_inc[7:0];
        end
      end
      if (dce_fall) begin
        state_q  <= IDLE;
        io_oe_q  <= 1'b0;
        io_out_q <= 1'b0;
        commit_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (dce_rise) begin
              state_q   <= CMD;
              bit_cnt_q <= 4'd0;
            end
          end
          CMD: begin
            if (dclk_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                addr_q    <= shift_d[CMD_ADDR_LSB+2:CMD_ADDR_LSB];
                bit_cnt_q <= 4'd0;
                if (!cmd_valid)
                  state_q <= WAIT;
                else if (shift_d[CMD_RD_BIT]) begin
                  state_q <= RDATA;
                  shift_q <= read_val;
                end else
                  state_q <= WDATA;
              end
            end
          end
          WDATA: begin
            if (commit_q) begin
              commit_q     <= 1'b0;
              frame_done_q <= 1'b1;
              state_q      <= WAIT;
              if (addr_q == REG_WP)
                wp_q <= shift_q[7];
              else if (!wp_q)
                regs_q[addr_q] <= shift_q;
            end else if (dclk_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7)
                commit_q <= 1'b1;
            end
          end
          RDATA: begin
            if (dclk_fall) begin
              if (bit_cnt_q == 4'd8) begin
                io_oe_q      <= 1'b0;
                io_out_q     <= 1'b0;
                frame_done_q <= 1'b1;
                state_q      <= WAIT;
              end else begin
                io_oe_q   <= 1'b1;
                io_out_q  <= shift_q[0];
                shift_q   <= {1'b0, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          WAIT:    ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sec        = regs_q[0];
  assign min        = regs_q[1];
  assign hour       = regs_q[2];
  assign date       = regs_q[3];
  assign month      = regs_q[4];
  assign week       = regs_q[5];
  assign year       = regs_q[6];
  assign wp         = wp_q;
  assign io_out     = io_out_q;
  assign io_oe      = io_oe_q;
  assign frame_done = frame_done_q;
  assign state_o    = state_q;

endmodule
